// File: rtl/seven_segment_display_ctrl_if.sv
// Bus bundle between a display client and the seven-segment controller.
// Latency: none, wires only.
// Backpressure: none; loads are always accepted and confirmed by load_ack.
interface seven_segment_display_ctrl_if #(
   parameter int NUM_DIGITS = 4
) ();
   logic [4*NUM_DIGITS-1:0] data_in;
   logic                    load;
   logic                    display_enable;
   logic                    blank_leading_zeros;
   logic                    blink_enable;
   logic [7*NUM_DIGITS-1:0] segments;
   logic                    load_ack;

   // Client side: drives value and display controls, observes the glyphs.
   modport master (
      output data_in,
      output load,
      output display_enable,
      output blank_leading_zeros,
      output blink_enable,
      input  segments,
      input  load_ack
   );

   // Controller side.
   modport slave (
      input  data_in,
      input  load,
      input  display_enable,
      input  blank_leading_zeros,
      input  blink_enable,
      output segments,
      output load_ack
   );
endinterface

// File: rtl/seven_segment_display_ctrl.sv
// Multi-digit hex seven-segment driver with leading-zero blanking and blink.
// Latency: load visible on segments two edges later; control inputs one edge later.
// Backpressure: none; every load is captured and acknowledged the next cycle.
module seven_segment_display_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic                       clk,
   input  logic                       reset,
   seven_segment_display_ctrl_if.slave bus
);
   localparam int DATA_W = 4 * NUM_DIGITS;
   localparam int SEG_W  = 7 * NUM_DIGITS;
   localparam int CNT_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(BLINK_DIV - 1);
   localparam logic [6:0]       GLYPH_BLANK = 7'h7F;

   // Active-low gfedcba glyph for one hex nibble; bit 0 is segment a.
   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      hex_glyph = GLYPH_BLANK;
      case (nib)
         4'h0: hex_glyph = 7'h40;
         4'h1: hex_glyph = 7'h79;
         4'h2: hex_glyph = 7'h24;
         4'h3: hex_glyph = 7'h30;
         4'h4: hex_glyph = 7'h19;
         4'h5: hex_glyph = 7'h12;
         4'h6: hex_glyph = 7'h02;
         4'h7: hex_glyph = 7'h78;
         4'h8: hex_glyph = 7'h00;
         4'h9: hex_glyph = 7'h10;
         4'hA: hex_glyph = 7'h08;
         4'hB: hex_glyph = 7'h03;
         4'hC: hex_glyph = 7'h46;
         4'hD: hex_glyph = 7'h21;
         4'hE: hex_glyph = 7'h06;
         4'hF: hex_glyph = 7'h0E;
         default: hex_glyph = GLYPH_BLANK;
      endcase
   endfunction

   logic [DATA_W-1:0] held_q;
   logic              load_ack_q;
   logic [CNT_W-1:0]  blink_cnt_q;
   logic              blink_phase_q;
   logic [SEG_W-1:0]  segments_q;

   logic [DATA_W-1:0] eff_val;
   logic [SEG_W-1:0]  seg_next;
   logic              blink_blank;
   logic              zero_run;
   logic [3:0]        nib;

   // Capture the display value on load; reset wins over a simultaneous load.
   always_ff @(posedge clk) begin
      if (reset) begin
         held_q     <= '0;
         load_ack_q <= 1'b0;
      end else begin
         load_ack_q <= bus.load;
         if (bus.load) begin
            held_q <= bus.data_in;
         end
      end
   end

   // Free-running blink divider; phase flips each time the counter wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else if (blink_cnt_q == CNT_LAST) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= ~blink_phase_q;
      end else begin
         blink_cnt_q   <= blink_cnt_q + 1'b1;
      end
   end

   // Disabling the display shows zeros but leaves the held value intact.
   assign eff_val     = bus.display_enable ? held_q : '0;
   assign blink_blank = bus.blink_enable & blink_phase_q;

   // Build the next glyph vector, walking from the most significant digit so
   // zero_run tells whether this digit and everything above it is zero.
   always_comb begin
      seg_next = '0;
      zero_run = 1'b1;
      nib      = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         nib      = eff_val[4*k +: 4];
         zero_run = zero_run & (nib == 4'h0);
         if (blink_blank || (bus.blank_leading_zeros && zero_run && (k != 0))) begin
            seg_next[7*k +: 7] = GLYPH_BLANK;
         end else begin
            seg_next[7*k +: 7] = hex_glyph(nib);
         end
      end
   end

   // Register the segment drive; reset blanks every digit.
   always_ff @(posedge clk) begin
      if (reset) begin
         segments_q <= {NUM_DIGITS{GLYPH_BLANK}};
      end else begin
         segments_q <= seg_next;
      end
   end

   assign bus.segments = segments_q;
   assign bus.load_ack = load_ack_q;
endmodule

// File: tb/tb_seven_segment_display_ctrl.sv
// Directed bench for seven_segment_display_ctrl at 1, 4 and 8 digits.
// Latency: expectations are sampled 1 time unit after each rising edge.
// Backpressure: not applicable; inputs are driven right after each edge.
module tb_seven_segment_display_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   pass_cnt = 0;
   int   chk_cnt  = 0;

   logic [27:0] exp4;
   logic [55:0] exp8;
   logic [6:0]  exp1;
   logic [6:0]  glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seven_segment_display_ctrl_if #(.NUM_DIGITS(4)) if4 ();
   seven_segment_display_ctrl_if #(.NUM_DIGITS(1)) if1 ();
   seven_segment_display_ctrl_if #(.NUM_DIGITS(8)) if8 ();

   seven_segment_display_ctrl #(.NUM_DIGITS(4), .BLINK_DIV(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
   seven_segment_display_ctrl #(.NUM_DIGITS(1), .BLINK_DIV(2)) dut1 (.clk(clk), .reset(reset), .bus(if1));
   seven_segment_display_ctrl #(.NUM_DIGITS(8), .BLINK_DIV(3)) dut8 (.clk(clk), .reset(reset), .bus(if8));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      exp4 = {4{7'h7F}};
      chk_cnt++; if (if4.segments !== exp4) $display("FAIL reset_seg4: got %h expected %h", if4.segments, exp4); else pass_cnt++;
      chk_cnt++; if (if4.load_ack !== 1'b0) $display("FAIL reset_ack4: got %b expected 0", if4.load_ack); else pass_cnt++;
      exp1 = 7'h7F;
      chk_cnt++; if (if1.segments !== exp1) $display("FAIL reset_seg1: got %h expected %h", if1.segments, exp1); else pass_cnt++;
      exp8 = {8{7'h7F}};
      chk_cnt++; if (if8.segments !== exp8) $display("FAIL reset_seg8: got %h expected %h", if8.segments, exp8); else pass_cnt++;
      reset = 1'b0;
      tick();
      exp4 = {4{7'h40}};
      chk_cnt++; if (if4.segments !== exp4) $display("FAIL post_reset_seg4: got %h expected %h", if4.segments, exp4); else pass_cnt++;
      exp8 = {8{7'h40}};
      chk_cnt++; if (if8.segments !== exp8) $display("FAIL post_reset_seg8: got %h expected %h", if8.segments, exp8); else pass_cnt++;
   endtask

   task automatic test_load_latency();
      if4.data_in = 16'h1A2F;
      if4.load    = 1'b1;
      tick();
      if4.load = 1'b0;
      chk_cnt++; if (if4.load_ack !== 1'b1) $display("FAIL load_ack_high: got %b expected 1", if4.load_ack); else pass_cnt++;
      exp4 = {4{7'h40}};
      chk_cnt++; if (if4.segments !== exp4) $display("FAIL load_not_yet: got %h expected %h", if4.segments, exp4); else pass_cnt++;
      tick();
      chk_cnt++; if (if4.load_ack !== 1'b0) $display("FAIL load_ack_low: got %b expected 0", if4.load_ack); else pass_cnt++;
      exp4 = {7'h79, 7'h08, 7'h24, 7'h0E};
      chk_cnt++; if (if4.segments !== exp4) $display("FAIL load_1a2f: got %h expected %h", if4.segments, exp4); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      if4.data_in = 16'h3456;
      if4.load    = 1'b1;
      tick();
      chk_cnt++; if (if4.load_ack !== 1'b1) $display("FAIL b2b_ack1: got %b expected 1", if4.load_ack); else pass_cnt++;
      if4.data_in = 16'h789C;
      tick();
      if4.load = 1'b0;
      chk_cnt++; if (if4.load_ack !== 1'b1) $display("FAIL b2b_ack2: got %b expected 1", if4.load_ack); else pass_cnt++;
      exp4 = {7'h30, 7'h19, 7'h12, 7'h02};
      chk_cnt++; if (if4.segments !== exp4) $display("FAIL b2b_seg1: got %h expected %h", if4.segments, exp4); else pass_cnt++;
      tick();
      chk_cnt++; if (if4.load_ack !== 1'b0) $display("FAIL b2b_ack3: got %b expected 0", if4.load_ack); else pass_cnt++;
      exp4 = {7'h78, 7'h00, 7'h10, 7'h46};
      chk_cnt++; if (if4.segments !== exp4) $display("FAIL b2b_seg2: got %h expected %h", if4.segments, exp4); else pass_cnt++;
   endtask

   task automatic test_suppression();
      if4.blank_leading_zeros = 1'b1;
      if4.data_in = 16'h0040;
      if4.load    = 1'b1;
      tick();
      if4.load = 1'b0;
      tick();
      exp4 = {7'h7F, 7'h7F, 7'h19, 7'h40};
      chk_cnt++; if (if4.segments !== exp4) $display("FAIL supp_0040: got %h expected %h", if4.segments, exp4); else pass_cnt++;
      if4.data_in = 16'h0000;
      if4.load    = 1'b1;
      tick();
      if4.load = 1'b0;
      tick();
      exp4 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
      chk_cnt++; if (if4.segments !== exp4) $display("FAIL supp_0000: got %h expected %h", if4.segments, exp4); else pass_cnt++;
      if4.blank_leading_zeros = 1'b0;
      tick();
      exp4 = {4{7'h40}};
      chk_cnt++; if (if4.segments !== exp4) $display("FAIL supp_off: got %h expected %h", if4.segments, exp4); else pass_cnt++;
   endtask

   task automatic test_display_enable();
      if4.data_in = 16'hBEEF;
      if4.load    = 1'b1;
      tick();
      if4.load = 1'b0;
      tick();
      exp4 = {7'h03, 7'h06, 7'h06, 7'h0E};
      chk_cnt++; if (if4.segments !== exp4) $display("FAIL beef_shown: got %h expected %h", if4.segments, exp4); else pass_cnt++;
      if4.display_enable = 1'b0;
      tick();
      exp4 = {4{7'h40}};
      chk_cnt++; if (if4.segments !== exp4) $display("FAIL disabled_zero: got %h expected %h", if4.segments, exp4); else pass_cnt++;
      if4.display_enable = 1'b1;
      tick();
      exp4 = {7'h03, 7'h06, 7'h06, 7'h0E};
      chk_cnt++; if (if4.segments !== exp4) $display("FAIL beef_restored: got %h expected %h", if4.segments, exp4); else pass_cnt++;
   endtask

   task automatic test_load_reset_collision();
      if4.data_in = 16'hFFFF;
      if4.load    = 1'b1;
      reset       = 1'b1;
      tick();
      chk_cnt++; if (if4.load_ack !== 1'b0) $display("FAIL collide_ack: got %b expected 0", if4.load_ack); else pass_cnt++;
      exp4 = {4{7'h7F}};
      chk_cnt++; if (if4.segments !== exp4) $display("FAIL collide_seg: got %h expected %h", if4.segments, exp4); else pass_cnt++;
      if4.load = 1'b0;
      reset    = 1'b0;
      tick();
      chk_cnt++; if (if4.load_ack !== 1'b0) $display("FAIL collide_ack2: got %b expected 0", if4.load_ack); else pass_cnt++;
      exp4 = {4{7'h40}};
      chk_cnt++; if (if4.segments !== exp4) $display("FAIL collide_held_zero: got %h expected %h", if4.segments, exp4); else pass_cnt++;
   endtask

   task automatic test_blink();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      if4.blink_enable = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         exp4 = (((i - 1) / 4) % 2 == 1) ? {4{7'h7F}} : {4{7'h40}};
         chk_cnt++; if (if4.segments !== exp4) $display("FAIL blink_cycle_%0d: got %h expected %h", i, if4.segments, exp4); else pass_cnt++;
      end
      tick();
      exp4 = {4{7'h7F}};
      chk_cnt++; if (if4.segments !== exp4) $display("FAIL blink_blank_again: got %h expected %h", if4.segments, exp4); else pass_cnt++;
      if4.blink_enable = 1'b0;
      tick();
      exp4 = {4{7'h40}};
      chk_cnt++; if (if4.segments !== exp4) $display("FAIL blink_drop: got %h expected %h", if4.segments, exp4); else pass_cnt++;
   endtask

   task automatic test_reset_mid_blink();
      if4.blink_enable = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp4 = {4{7'h7F}};
      chk_cnt++; if (if4.segments !== exp4) $display("FAIL midblink_reset_seg: got %h expected %h", if4.segments, exp4); else pass_cnt++;
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp4 = (i > 4) ? {4{7'h7F}} : {4{7'h40}};
         chk_cnt++; if (if4.segments !== exp4) $display("FAIL midblink_cycle_%0d: got %h expected %h", i, if4.segments, exp4); else pass_cnt++;
      end
      if4.blink_enable = 1'b0;
   endtask

   task automatic test_one_digit();
      if1.blank_leading_zeros = 1'b1;
      for (int v = 0; v < 16; v++) begin
         if1.data_in = v[3:0];
         if1.load    = 1'b1;
         tick();
         if1.load = 1'b0;
         tick();
         exp1 = glyph_tab[v];
         chk_cnt++; if (if1.segments !== exp1) $display("FAIL one_digit_%0h: got %h expected %h", v, if1.segments, exp1); else pass_cnt++;
      end
   endtask

   task automatic test_eight_digits();
      if8.data_in = 32'h12345678;
      if8.load    = 1'b1;
      tick();
      if8.load = 1'b0;
      tick();
      exp8 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
      chk_cnt++; if (if8.segments !== exp8) $display("FAIL eight_12345678: got %h expected %h", if8.segments, exp8); else pass_cnt++;
      if8.blank_leading_zeros = 1'b1;
      if8.data_in = 32'h00000001;
      if8.load    = 1'b1;
      tick();
      if8.load = 1'b0;
      tick();
      exp8 = {{7{7'h7F}}, 7'h79};
      chk_cnt++; if (if8.segments !== exp8) $display("FAIL eight_00000001: got %h expected %h", if8.segments, exp8); else pass_cnt++;
      if8.data_in = 32'h00C0D000;
      if8.load    = 1'b1;
      tick();
      if8.load = 1'b0;
      tick();
      exp8 = {7'h7F, 7'h7F, 7'h46, 7'h40, 7'h21, 7'h40, 7'h40, 7'h40};
      chk_cnt++; if (if8.segments !== exp8) $display("FAIL eight_00c0d000: got %h expected %h", if8.segments, exp8); else pass_cnt++;
   endtask

   initial begin
      reset = 1'b1;
      if4.data_in = '0; if4.load = 1'b0; if4.display_enable = 1'b1;
      if4.blank_leading_zeros = 1'b0; if4.blink_enable = 1'b0;
      if1.data_in = '0; if1.load = 1'b0; if1.display_enable = 1'b1;
      if1.blank_leading_zeros = 1'b0; if1.blink_enable = 1'b0;
      if8.data_in = '0; if8.load = 1'b0; if8.display_enable = 1'b1;
      if8.blank_leading_zeros = 1'b0; if8.blink_enable = 1'b0;

      test_reset();
      test_load_latency();
      test_back_to_back();
      test_suppression();
      test_display_enable();
      test_load_reset_collision();
      test_blink();
      test_reset_mid_blink();
      test_one_digit();
      test_eight_digits();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/seven_segment_display_ctrl.md
SEVEN_SEGMENT_DISPLAY_CTRL -- requirements
Module: seven_segment_display_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of hex digits driven; legal range 1..8.
REQ-002 Parameter BLINK_DIV, default 25000000: clk cycles per blink half-period; legal range >= 2.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port data_in, input, 4*NUM_DIGITS: value to display; nibble k drives digit k, with digit 0 least significant.
REQ-006 Port load, input, 1: capture data_in at this edge.
REQ-007 Port display_enable, input, 1: 0 forces the effective value to zero.
REQ-008 Port blank_leading_zeros, input, 1: enables leading-zero suppression.
REQ-009 Port blink_enable, input, 1: enables periodic blanking of all digits.
REQ-010 Port segments, output, 7*NUM_DIGITS: registered, active-low gfedcba per digit; bits [7k+6:7k] drive digit k, and bit 0 of each group is segment a.
REQ-011 Port load_ack, output, 1: one-cycle pulse confirming a capture.

Function
REQ-012 Held register: at an edge with load=1 and reset=0, SHALL capture data_in; otherwise SHALL hold its value.
REQ-013 load_ack: SHALL be 1 in the cycle after each capture, otherwise 0; back-to-back loads give back-to-back acks.
REQ-014 Effective value: SHALL equal the held register when display_enable=1; SHALL be all zeros when display_enable=0. The held register SHALL be preserved while disabled.
REQ-015 Glyphs, nibble 0..F, SHALL be: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex). Blank SHALL be 7F.
REQ-016 Leading-zero suppression: when blank_leading_zeros=1, each digit k>=1 SHALL be blank if effective nibbles k..NUM_DIGITS-1 are all zero. Digit 0 SHALL never be suppressed.
REQ-017 Blink counter: SHALL count 0..BLINK_DIV-1 every cycle and wrap to 0; on the wrap, blink_phase SHALL toggle.
REQ-018 Blink counter and blink_phase SHALL run regardless of blink_enable.
REQ-019 When blink_enable=1 and blink_phase=1, all digits SHALL be blank (overrides REQ-015/016).
REQ-020 segments SHALL be registered from the effective value, suppression, and blink state at each edge.
REQ-021 Latency: a load at edge N SHALL appear on segments after edge N+1.
REQ-022 Latency: a change on display_enable, blank_leading_zeros, or blink_enable SHALL appear on segments after the following edge.
REQ-023 Simultaneous load and reset: reset SHALL win; no capture occurs and load_ack stays 0.
REQ-024 Widths: the blink counter SHALL be clog2(BLINK_DIV) bits. No arithmetic beyond the counter increment.

Reset
REQ-025 Reset SHALL clear the held register, the blink counter, blink_phase and load_ack to 0.
REQ-026 Reset SHALL drive every digit of segments to 7F (blank) after the reset edge.
REQ-027 After reset deasserts, segments SHALL reflect the zero value per REQ-014..019 after the next edge.
REQ-028 Reset asserted mid-blink SHALL restart the blink period from counter 0 with phase 0.

Verification
REQ-029 Scenario: NUM_DIGITS=4, load 16'h1A2F, enable=1, suppression off, blink off -> after 2 edges, segments = {79,08,24,0E}, digit3..0; load_ack high exactly one cycle.
REQ-030 Scenario: load 16'h0040, suppression on -> digits 3,2 = 7F; digit1 = 19; digit0 = 40. Load 16'h0000 -> only digit0 shows 40.
REQ-031 Scenario: held 16'hBEEF, toggle display_enable to 0 -> all digits 40. Return to 1 -> BEEF glyphs {03,06,06,0E} restored without a reload.
REQ-032 Scenario: BLINK_DIV=4, blink_enable=1 -> segments alternate 4 cycles shown / 4 cycles 7F. Drop blink_enable during the blank phase -> digits reappear after 1 edge.
REQ-033 Scenario: assert load and reset on the same edge with data 16'hFFFF -> held stays 0, load_ack=0, segments all 7F. Reset asserted mid-blink -> counter restarts at 0.
REQ-034 Scenario: NUM_DIGITS=1 and NUM_DIGITS=8 -> segment width 7 and 56 respectively; for NUM_DIGITS=8, loading 32'h00000001 with suppression on blanks digits 7..1.
